// File: rtl/gf_mult_serial.sv
// rtl/gf_mult_serial.sv - bit-serial GF(2^M) multiplier with valid/ready handshakes
//
// Computes z = a*b mod P(x), P(x) = x^M + POLY(x), one multiplier bit per
// clock, MSB first. Optional macro: GF_MULT_SERIAL_ZERO_SKIP_EN (a zero
// operand skips straight to DONE with z=0).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands a, b valid
//   in_ready   operands accepted this cycle (IDLE and out of reset)
//   a, b       multiplicand / multiplier, bit i = coefficient of x^i
//   out_valid  z holds a completed product
//   out_ready  consumer takes z this cycle
//   z          registered product
//   busy       high while in BUSY
module gf_mult_serial #(
  parameter int           M    = 4,
  parameter logic [M-1:0] POLY = 'b0011
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] z,
  output logic         busy
);

  localparam int CW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic           rst_q;
  logic [M-1:0]   areg;
  logic [M-1:0]   breg;
  logic [M-1:0]   acc;
  logic [M-1:0]   acc_step;
  logic [M-1:0]   z_r;
  logic [CW-1:0]  cnt;
  logic           accept;

  // rst_q keeps in_ready low for the whole reset interval and the cycle in
  // which rst drops, without a combinational path from rst to in_ready.
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  assign in_ready  = (state == IDLE) && !rst_q;
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign z         = z_r;
  assign accept    = in_valid && in_ready;

  // Horner step: multiply running sum by x, reduce, add the next partial product.
  always_comb begin
    acc_step = {acc[M-2:0], 1'b0} ^ (acc[M-1] ? POLY : '0);
    if (breg[cnt]) begin
      acc_step = acc_step ^ areg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
`ifdef GF_MULT_SERIAL_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            state_nxt = DONE;
          end else begin
            state_nxt = BUSY;
          end
`else
          state_nxt = BUSY;
`endif
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      areg <= '0;
      breg <= '0;
      acc  <= '0;
      cnt  <= '0;
      z_r  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            areg <= a;
            breg <= b;
            acc  <= '0;
            cnt  <= CW'(M - 1);
`ifdef GF_MULT_SERIAL_ZERO_SKIP_EN
            if ((a == '0) || (b == '0)) begin
              z_r <= '0;
            end
`endif
          end
        end
        BUSY: begin
          acc <= acc_step;
          cnt <= cnt - 1'b1;
          if (cnt == '0) begin
            z_r <= acc_step;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
